// File: rtl/fpnew_pkg.sv
// Shared FP format helpers and class-mask definitions for the fpnew operand path.
package fpnew_pkg;

   typedef enum logic [2:0] {
      FP32    = 3'd0,
      FP64    = 3'd1,
      FP16    = 3'd2,
      FP8     = 3'd3,
      FP16ALT = 3'd4
   } fp_format_e;

   typedef logic [9:0] classmask_t;

   localparam int unsigned CLASS_NEG_INF  = 0;
   localparam int unsigned CLASS_NEG_NORM = 1;
   localparam int unsigned CLASS_NEG_SUB  = 2;
   localparam int unsigned CLASS_NEG_ZERO = 3;
   localparam int unsigned CLASS_POS_ZERO = 4;
   localparam int unsigned CLASS_POS_SUB  = 5;
   localparam int unsigned CLASS_POS_NORM = 6;
   localparam int unsigned CLASS_POS_INF  = 7;
   localparam int unsigned CLASS_SNAN     = 8;
   localparam int unsigned CLASS_QNAN     = 9;

   function automatic int unsigned exp_bits(fp_format_e fmt);
      case (fmt)
         FP32:    return 8;
         FP64:    return 11;
         FP16:    return 5;
         FP8:     return 5;
         FP16ALT: return 8;
         default: return 8;
      endcase
   endfunction

   function automatic int unsigned man_bits(fp_format_e fmt);
      case (fmt)
         FP32:    return 23;
         FP64:    return 52;
         FP16:    return 10;
         FP8:     return 2;
         FP16ALT: return 7;
         default: return 23;
      endcase
   endfunction

   function automatic int unsigned fp_width(fp_format_e fmt);
      return 1 + exp_bits(fmt) + man_bits(fmt);
   endfunction

endpackage

// File: rtl/fpnew_classifier_stage.sv
// One valid/ready register slice; a drained downstream or an empty slot lets new data in.
module fpnew_classifier_stage #(
   parameter int unsigned DataWidth = 14
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [DataWidth-1:0] in_data_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [DataWidth-1:0] out_data_o
);

   logic                 valid_q;
   logic [DataWidth-1:0] data_q;

   assign in_ready_o  = out_ready_i | ~valid_q;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (in_ready_o) begin
         valid_q <= in_valid_i;
         if (in_valid_i) data_q <= in_data_i;
      end
   end

endmodule

// File: rtl/fpnew_classifier.sv
// fclass-style operand classifier with a NumPipeRegs-deep valid/ready pipe.
// Optional NaN handshake counter enabled by FPNEW_CLASSIFIER_NAN_COUNT_EN.
module fpnew_classifier
   import fpnew_pkg::*;
#(
   parameter fp_format_e  FpFormat    = fp_format_e'(0),
   parameter int unsigned NumPipeRegs = 1,
   parameter int unsigned TagWidth    = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          flush_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [fp_width(FpFormat)-1:0] operand_i,
   input  logic [TagWidth-1:0]           tag_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output classmask_t                    class_o,
   output logic                          is_nan_o,
   output logic                          is_snan_o,
   output logic [TagWidth-1:0]           tag_o,
   output logic                          busy_o,
   output logic [15:0]                   nan_count_o
);

   localparam int unsigned WIDTH    = fp_width(FpFormat);
   localparam int unsigned EXP_BITS = exp_bits(FpFormat);
   localparam int unsigned MAN_BITS = man_bits(FpFormat);

   typedef struct packed {
      classmask_t          cls;
      logic [TagWidth-1:0] tag;
   } payload_t;

   logic                sign;
   logic [EXP_BITS-1:0] exp_v;
   logic [MAN_BITS-1:0] man_v;
   classmask_t          cls_d;
   payload_t            in_data, out_data;

   assign sign  = operand_i[WIDTH-1];
   assign exp_v = operand_i[WIDTH-2 -: EXP_BITS];
   assign man_v = operand_i[MAN_BITS-1:0];

   always_comb begin
      cls_d = '0;
      if (&exp_v) begin
         // NaN sign is irrelevant; the quiet bit alone picks the class
         if (man_v == '0)           cls_d[sign ? CLASS_NEG_INF : CLASS_POS_INF] = 1'b1;
         else if (man_v[MAN_BITS-1]) cls_d[CLASS_QNAN] = 1'b1;
         else                       cls_d[CLASS_SNAN] = 1'b1;
      end else if (exp_v == '0) begin
         if (man_v == '0) cls_d[sign ? CLASS_NEG_ZERO : CLASS_POS_ZERO] = 1'b1;
         else             cls_d[sign ? CLASS_NEG_SUB  : CLASS_POS_SUB]  = 1'b1;
      end else begin
         cls_d[sign ? CLASS_NEG_NORM : CLASS_POS_NORM] = 1'b1;
      end
   end

   assign in_data.cls = cls_d;
   assign in_data.tag = tag_i;

   if (NumPipeRegs == 0) begin : g_comb
      assign in_ready_o  = out_ready_i & ~flush_i & rst_ni;
      assign out_valid_o = in_valid_i & ~flush_i & rst_ni;
      assign out_data    = in_data;
      assign busy_o      = 1'b0;
   end else begin : g_pipe
      logic     [NumPipeRegs:0] vld_pipe;
      logic     [NumPipeRegs:0] rdy_pipe;
      payload_t [NumPipeRegs:0] dat_pipe;

      assign vld_pipe[0]           = in_valid_i;
      assign dat_pipe[0]           = in_data;
      assign rdy_pipe[NumPipeRegs] = out_ready_i;

      for (genvar i = 0; i < NumPipeRegs; i++) begin : g_stage
         fpnew_classifier_stage #(
            .DataWidth($bits(payload_t))
         ) u_stage (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .flush_i    (flush_i),
            .in_valid_i (vld_pipe[i]),
            .in_ready_o (rdy_pipe[i]),
            .in_data_i  (dat_pipe[i]),
            .out_valid_o(vld_pipe[i+1]),
            .out_ready_i(rdy_pipe[i+1]),
            .out_data_o (dat_pipe[i+1])
         );
      end

      // Stage 0 itself ignores input during flush/reset; gating here keeps the handshake honest
      assign in_ready_o  = rdy_pipe[0] & ~flush_i & rst_ni;
      assign out_valid_o = vld_pipe[NumPipeRegs];
      assign out_data    = dat_pipe[NumPipeRegs];
      assign busy_o      = |vld_pipe[NumPipeRegs:1];
   end

   assign class_o   = out_data.cls;
   assign tag_o     = out_data.tag;
   assign is_nan_o  = out_data.cls[CLASS_SNAN] | out_data.cls[CLASS_QNAN];
   assign is_snan_o = out_data.cls[CLASS_SNAN];

`ifdef FPNEW_CLASSIFIER_NAN_COUNT_EN
   logic [15:0] nan_cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         nan_cnt_q <= '0;
      end else if (out_valid_o && out_ready_i && is_nan_o && (nan_cnt_q != 16'hFFFF)) begin
         nan_cnt_q <= nan_cnt_q + 16'd1;
      end
   end

   assign nan_count_o = nan_cnt_q;
`else
   assign nan_count_o = '0;
`endif

endmodule

// File: doc/fpnew_classifier.md
Name: fpnew_classifier

Overview:
- Pipelined operand classifier. Takes packed FP operands of one compile-time format and produces a RISC-V fclass-style one-hot class mask plus NaN/sNaN flags.
- Decode-side counterpart to the FMA special-result generation: it recognises canonical qNaN, signed infinity, zero, subnormal and normal encodings.
- Sits in front of the FMA/ops units. Uses a valid/ready handshake with tag passthrough.

Parameters:
- FpFormat, fpnew_pkg::fp_format_e'(0) (FP32): operand format. WIDTH = 1 + exp_bits(FpFormat) + man_bits(FpFormat).
- NumPipeRegs, 1: number of register stages, 0..4. 0 makes the block purely combinational, input to output.
- TagWidth, 4: width of the opaque tag carried alongside each operand.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- flush_i  in  1  synchronous kill of all in-flight entries
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  block accepts operand
- operand_i  in  WIDTH  packed {sign, exponent, mantissa}
- tag_i  in  TagWidth  opaque tag
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts
- class_o  out  10  one-hot class mask
- is_nan_o  out  1  class_o[8] | class_o[9]
- is_snan_o  out  1  class_o[8]
- tag_o  out  TagWidth  tag of the result
- busy_o  out  1  any stage valid
- nan_count_o  out  16  NaN counter (see Optional Feature)

Behaviour:
- Class bits:
  - 0 -inf, 1 -normal, 2 -subnormal, 3 -zero
  - 4 +zero, 5 +subnormal, 6 +normal, 7 +inf
  - 8 sNaN, 9 qNaN
- Exactly one bit is set per valid result.
- Decode rules:
  - exp=all-ones, man=0: inf.
  - exp=all-ones, man!=0: NaN. Mantissa MSB=1 gives qNaN, else sNaN. The sign is ignored for NaN.
  - exp=0, man=0: zero.
  - exp=0, man!=0: subnormal.
  - Otherwise: normal.
- Classification is combinational at the input. The result, flags and tag are then registered through NumPipeRegs stages.
- Each stage has a valid bit. Per-stage ready = next_ready | ~valid, so bubbles collapse. in_ready_o is the stage-0 ready.
- Latency is NumPipeRegs cycles with no backpressure. Throughput is 1 per cycle.
- With out_valid_o=1 and out_ready_i=0, all outputs hold stable until accepted.
- Reset (rst_ni=0 at a clk_i edge):
  - All valid bits clear and all data registers clear to 0.
  - out_valid_o=0, class_o=0, is_nan_o=0, is_snan_o=0, tag_o=0, busy_o=0, nan_count_o=0.
  - While rst_ni=0, in_ready_o=0.
- Reset mid-operation drops all in-flight entries; no output handshake occurs for them.
- flush_i=1:
  - All valid bits clear at the next edge.
  - in_ready_o=0 that cycle, so a simultaneous input is not accepted.
  - Reset has priority over flush.
- Simultaneous accept and output on a full pipe with out_ready_i=1: the pipe shifts, and the occupancy is unchanged.
- NumPipeRegs=0:
  - Outputs are combinational from the inputs.
  - in_ready_o = out_ready_i & ~flush_i & rst_ni.
  - busy_o=0.
- Input handshake is valid/ready. in_valid_i must not depend on in_ready_o.

Optional Feature:
- Macro FPNEW_CLASSIFIER_NAN_COUNT_EN.
- Defined:
  - A 16-bit counter increments on each output handshake (out_valid_o & out_ready_i) whose is_nan_o=1.
  - The counter saturates at 16'hFFFF.
  - It is cleared by reset only; flush does not clear it.
  - The value is driven on nan_count_o.
- Undefined: no counter is built and nan_count_o is tied to 0.

Decomposition:
- Package fpnew_pkg gains:
  - function fp_width(fmt)
  - typedef classmask_t (logic [9:0])
  - localparams CLASS_NEG_INF .. CLASS_QNAN for bit indices 0..9
- One sub-module: fpnew_classifier_stage. It is a single valid/ready register slice for {classmask_t, tag}, generate-instantiated NumPipeRegs times.

Test Plan (FpFormat=FP64, NumPipeRegs=2 unless noted):
- Operand 64'h7FF8000000000000, out_ready_i=1 -> after 2 cycles: class_o=10'h200, is_nan_o=1, is_snan_o=0.
- Operands 64'hFFF0000000000000, 64'h8000000000000000, 64'h0000000000000001, 64'h7FF0000000000001, one per cycle -> class_o sequence 10'h001, 10'h008, 10'h020, 10'h100 on consecutive cycles; tags preserved in order.
- 5 back-to-back inputs with out_ready_i=0 -> exactly 2 accepted, then in_ready_o=0; outputs stable. Raising out_ready_i drains results in order with no loss or duplication.
- Two entries in flight, assert flush_i together with in_valid_i -> no output valid afterwards, busy_o=0 next cycle, the input is not accepted.
- rst_ni=0 for 1 cycle with the pipe full -> out_valid_o=0, busy_o=0, class_o=0. The first post-reset input emerges 2 cycles after acceptance.
- With FPNEW_CLASSIFIER_NAN_COUNT_EN defined, 3 NaN and 2 normal inputs handshaken -> nan_count_o=3. Without the macro, nan_count_o=0.
